// File: rtl/spi_master.sv
// Single-transaction SPI mode-0 master: serialises {addr, rw, wdata} into a 16-bit frame and
// captures the read byte returned on miso. All outputs are registered.
module spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP - 1);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      bit_q, bit_d;
  // Frame bits still to be sent; the first bit goes straight to mosi when the frame starts.
  logic [14:0]     shift_q, shift_d;
  logic            rw_q, rw_d;
  logic [7:0]      rsr_q, rsr_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            half_end;

  assign half_end = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    rsr_d   = rsr_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = {addr[5:0], rw, wdata};
          rw_d    = rw;
          mosi_d  = addr[6];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          rsr_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (half_end) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + DivOne;
        end
      end
      StShift: begin
        if (half_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: data phase of a read occupies bits 8..15.
            if (bit_q[3] && rw_q) begin
              rsr_d = {rsr_q[6:0], miso_pin};
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            mosi_d  = shift_q[14];
            shift_d = {shift_q[13:0], 1'b0};
            if (bit_q == 4'd15) begin
              mosi_d  = 1'b0;
              state_d = StHold;
            end
          end
        end else begin
          div_d = div_q + DivOne;
        end
      end
      StHold: begin
        if (half_end) begin
          div_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = StGap;
          if (rw_q) begin
            rdata_d = rsr_q;
          end
        end else begin
          div_d = div_q + DivOne;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      rsr_q   <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      rsr_q   <= rsr_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI memory slave plus a reference memory model check
// frames, latency, read data, back-to-back spacing, reset abort and sclk timing at other dividers.
module tb_spi_master;

  localparam int D = 4;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk, cs, mosi;
  logic       miso = 1'b0;
  logic [7:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(D), .GAP(G)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk), .cs_pin(cs),
    .mosi_pin(mosi), .miso_pin(miso)
  );

  // Two extra instances for divider timing checks, driven together.
  logic       t_start = 1'b0, t_rw = 1'b0;
  logic [6:0] t_addr = '0;
  logic [7:0] t_wdata = '0;
  logic       t_miso = 1'b0;
  logic       t_busy [2], t_done [2], t_sclk [2], t_cs [2], t_mosi [2];
  logic [7:0] t_rdata [2];
  int         divs [2] = '{2, 7};

  spi_master #(.CLK_DIV(2), .GAP(G)) u_div2 (
    .clk(clk), .reset(reset), .start(t_start), .rw(t_rw), .addr(t_addr), .wdata(t_wdata),
    .busy(t_busy[0]), .done(t_done[0]), .rdata(t_rdata[0]), .sclk_pin(t_sclk[0]),
    .cs_pin(t_cs[0]), .mosi_pin(t_mosi[0]), .miso_pin(t_miso)
  );

  spi_master #(.CLK_DIV(7), .GAP(G)) u_div7 (
    .clk(clk), .reset(reset), .start(t_start), .rw(t_rw), .addr(t_addr), .wdata(t_wdata),
    .busy(t_busy[1]), .done(t_done[1]), .rdata(t_rdata[1]), .sclk_pin(t_sclk[1]),
    .cs_pin(t_cs[1]), .mosi_pin(t_mosi[1]), .miso_pin(t_miso)
  );

  // Behavioural SPI memory slave on the main instance, sampled mid-cycle.
  logic [7:0]  mem [128];
  logic [7:0]  ref_mem [128];
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, mosi_before = 1'b0;
  logic [15:0] cap = '0;
  logic [7:0]  sbyte = '0;
  int          rises = 0, falls = 0, total_rises = 0, done_cnt = 0, cs_falls = 0, stab_err = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_cs && !cs) begin
      rises = 0; falls = 0; cap = '0; sbyte = '0; cs_falls++;
    end
    if (!prev_sclk && sclk) begin
      total_rises++;
      if (!cs) begin
        if (mosi !== mosi_before) stab_err++;
        cap = {cap[14:0], mosi};
        rises++;
        if (rises == 8 && cap[0]) sbyte = mem[cap[7:1]];
        if (rises == 16 && !cap[8]) mem[cap[15:9]] = cap[7:0];
      end
    end
    if (prev_sclk && !sclk && !cs) begin
      falls++;
      miso = (falls >= 8 && falls <= 15) ? sbyte[15 - falls] : 1'b0;
    end
    mosi_before = mosi;
    prev_sclk = sclk;
    prev_cs = cs;
  end

  // Run-length monitor for the two timing instances.
  int          t_rises [2], t_run [2], t_bad [2], t_stab [2];
  logic        t_valid [2], t_psclk [2], t_pmosi [2], t_pcs [2];
  logic [15:0] t_cap [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      t_rises[k] = 0; t_run[k] = 0; t_bad[k] = 0; t_stab[k] = 0; t_valid[k] = 1'b0;
      t_psclk[k] = 1'b0; t_pmosi[k] = 1'b0; t_pcs[k] = 1'b1; t_cap[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (t_pcs[k] && !t_cs[k]) begin
        t_rises[k] = 0; t_valid[k] = 1'b0; t_cap[k] = '0;
      end
      if (t_sclk[k] !== t_psclk[k]) begin
        if (t_valid[k] && t_run[k] != divs[k]) t_bad[k]++;
        t_valid[k] = 1'b1;
        t_run[k] = 1;
        if (t_sclk[k] && !t_cs[k]) begin
          t_rises[k]++;
          t_cap[k] = {t_cap[k][14:0], t_mosi[k]};
          if (t_mosi[k] !== t_pmosi[k]) t_stab[k]++;
        end
      end else begin
        t_run[k]++;
      end
      t_psclk[k] = t_sclk[k];
      t_pmosi[k] = t_mosi[k];
      t_pcs[k] = t_cs[k];
    end
  end

  // One full transaction against the reference model; noisy adds ignored start pulses mid-frame.
  task automatic do_frame(input logic [6:0] a, input logic r, input logic [7:0] w,
                          input logic noisy);
    logic [7:0]  exp_rd;
    logic [15:0] exp_frame, mask;
    int lat, dc0, cf0, se0, bcyc;
    exp_rd = r ? ref_mem[a] : rdata;
    exp_frame = {a, r, w};
    mask = r ? 16'hFF00 : 16'hFFFF;
    dc0 = done_cnt; cf0 = cs_falls; se0 = stab_err;
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = w;
    lat = 0;
    while (1) begin
      @(posedge clk); lat++; @(negedge clk);
      if (done || lat > 40 * D) break;
      start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
      rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    end
    start = 1'b0;
    n_chk++;
    if (lat !== 34 * D + 1) begin
      n_fail++; $display("FAIL latency: got %0d want %0d", lat, 34 * D + 1);
    end
    n_chk++;
    if (cs !== 1'b1) begin n_fail++; $display("FAIL cs_at_done: got %b want 1", cs); end
    n_chk++;
    if (rdata !== exp_rd) begin
      n_fail++; $display("FAIL rdata a=%h r=%b: got %h want %h", a, r, rdata, exp_rd);
    end
    n_chk++;
    if (rises !== 16) begin n_fail++; $display("FAIL rise_count: got %0d want 16", rises); end
    n_chk++;
    if ((cap & mask) !== (exp_frame & mask)) begin
      n_fail++; $display("FAIL mosi_frame: got %h want %h", cap & mask, exp_frame & mask);
    end
    n_chk++;
    if (stab_err !== se0) begin
      n_fail++; $display("FAIL mosi_stable: got %0d errors want 0", stab_err - se0);
    end
    bcyc = 0;
    while (busy === 1'b1 && bcyc <= G + 4) begin
      @(posedge clk); bcyc++; @(negedge clk);
      n_chk++;
      if (bcyc == 1 && done !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse: got %b want 0", done);
      end
    end
    n_chk++;
    if (bcyc !== G) begin n_fail++; $display("FAIL gap_busy: got %0d want %0d", bcyc, G); end
    n_chk++;
    if (done_cnt - dc0 !== 1 || cs_falls - cf0 !== 1) begin
      n_fail++; $display("FAIL one_frame: got %0d done %0d cs_fall want 1 1",
                         done_cnt - dc0, cs_falls - cf0);
    end
    if (!r) ref_mem[a] = w;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, done, rdata, sclk, cs, mosi} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b done=%b rdata=%h sclk=%b cs=%b mosi=%b",
               busy, done, rdata, sclk, cs, mosi);
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    do_frame(7'h61, 1'b0, 8'hB1, 1'b0);
    n_chk++;
    if (cap !== 16'hC2B1) begin n_fail++; $display("FAIL write_bits: got %h want c2b1", cap); end
  endtask

  task automatic test_read();
    mem[7'h61] = 8'hB1;
    ref_mem[7'h61] = 8'hB1;
    do_frame(7'h61, 1'b1, 8'h5A, 1'b0);
  endtask

  task automatic test_end_to_end();
    do_frame(7'h00, 1'b0, 8'hCE, 1'b0);
    do_frame(7'h00, 1'b1, 8'h00, 1'b0);
    n_chk++;
    if (rdata !== 8'hCE) begin n_fail++; $display("FAIL e2e_read: got %h want ce", rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_frame(7'($urandom), 1'($urandom), 8'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int dc0, cf0, cyc, run, min_gap;
    logic seen_done;
    dc0 = done_cnt; cf0 = cs_falls; cyc = 0; run = 0; min_gap = 1000; seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom);
    while (done_cnt - dc0 < 3 && cyc < 3 * (40 * D + G)) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (done) seen_done = 1'b1;
      if (cs) run++;
      else begin
        if (seen_done && run > 0 && run < min_gap) min_gap = run;
        run = 0;
      end
    end
    start = 1'b0;
    repeat (G + 4) @(negedge clk);
    n_chk++;
    if (done_cnt - dc0 !== 3) begin
      n_fail++; $display("FAIL b2b_dones: got %0d want 3", done_cnt - dc0);
    end
    n_chk++;
    if (cs_falls - cf0 !== 3) begin
      n_fail++; $display("FAIL b2b_frames: got %0d want 3", cs_falls - cf0);
    end
    n_chk++;
    if (min_gap < G || min_gap == 1000) begin
      n_fail++; $display("FAIL b2b_gap: got %0d want >= %0d", min_gap, G);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int tr0, dc0;
    if (rdata === 8'h00) begin
      mem[7'h11] = 8'h3C; ref_mem[7'h11] = 8'h3C;
      do_frame(7'h11, 1'b1, 8'h00, 1'b0);
    end
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'($urandom); wdata = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (20 * D) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({cs, sclk, busy, done, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_state: got cs=%b sclk=%b busy=%b done=%b rdata=%h",
               cs, sclk, busy, done, rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tr0 = total_rises; dc0 = done_cnt;
    repeat (50 * D) @(negedge clk);
    n_chk++;
    if (total_rises !== tr0 || done_cnt !== dc0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d rises %0d dones want 0 0",
                         total_rises - tr0, done_cnt - dc0);
    end
  endtask

  task automatic test_timing();
    int lat [2];
    int cyc;
    logic [15:0] exp_frame, mask;
    lat[0] = -1; lat[1] = -1; cyc = 0;
    @(negedge clk);
    t_start = 1'b1; t_rw = 1'($urandom); t_addr = 7'($urandom); t_wdata = 8'($urandom);
    exp_frame = {t_addr, t_rw, t_wdata};
    mask = t_rw ? 16'hFF00 : 16'hFFFF;
    while ((lat[0] < 0 || lat[1] < 0) && cyc < 40 * 7) begin
      @(posedge clk); cyc++; @(negedge clk);
      t_start = 1'b0;
      for (int k = 0; k < 2; k++) if (t_done[k] && lat[k] < 0) lat[k] = cyc;
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (lat[k] !== 34 * divs[k] + 1) begin
        n_fail++; $display("FAIL div%0d_latency: got %0d want %0d", divs[k], lat[k],
                           34 * divs[k] + 1);
      end
      n_chk++;
      if (t_rises[k] !== 16 || t_bad[k] !== 0 || t_stab[k] !== 0) begin
        n_fail++; $display("FAIL div%0d_timing: got rises=%0d bad_runs=%0d unstable=%0d want 16 0 0",
                           divs[k], t_rises[k], t_bad[k], t_stab[k]);
      end
      n_chk++;
      if ((t_cap[k] & mask) !== (exp_frame & mask)) begin
        n_fail++; $display("FAIL div%0d_frame: got %h want %h", divs[k], t_cap[k] & mask,
                           exp_frame & mask);
      end
    end
    repeat (G + 4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_end_to_end();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
